fft_frame_feeder: RTL and testbench

- Stream adapter between fft_requestor (read-response side) and the fft core input (data_in/next_in).
- The fft core needs each frame as one next pulse followed by FRAME_WORDS consecutive 512-bit words, with no stalls.
- Read responses arrive irregularly, so this block accumulates complete frames in a ping-pong buffer and launches each one as a gap-free burst.
- Back-pressure to the requestor is a valid/ready handshake.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_frame_bank.sv | 35 +++
 rtl/fft_frame_feeder.sv | 156 +++++++++++++++
 tb/tb_fft_frame_feeder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the fft input path: word type, frame geometry
// and the frame feeder read-side state encoding.
package fft_pkg;

  localparam int FFT_DATA_WIDTH  = 512;
  localparam int FFT_FRAME_WORDS = 4;
  localparam int FFT_CNT_WIDTH   = 32;

  typedef logic [FFT_DATA_WIDTH-1:0] t_fft_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    STREAM = 2'd2
  } t_feeder_state;

  // Index width for a power-of-two frame; never below one bit.
  function automatic int fft_idx_w(input int frame_words);
    int w;
    w = 1;
    while ((1 << w) < frame_words) w++;
    return w;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// Simple dual-port word store for the ping-pong frame buffer: one write port,
// one read port with a single cycle of registered read latency.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fft_frame_feeder.sv
// Collects irregular read responses into a two-bank frame buffer and replays each
// complete frame to the fft core as a next strobe followed by a gap-free burst.
module fft_frame_feeder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int FRAME_WORDS = FFT_FRAME_WORDS,
  parameter int CNT_WIDTH   = FFT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  next_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_in,
  output logic [CNT_WIDTH-1:0]  frames_out
);

  localparam int IDX_W  = fft_idx_w(FRAME_WORDS);
  localparam int ADDR_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  t_feeder_state        state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0] frames_in_q, frames_in_d;
  logic [CNT_WIDTH-1:0] frames_out_q, frames_out_d;

  logic                  wr_fire;
  logic                  wr_last;
  logic                  ram_rd_en;
  logic [ADDR_W-1:0]     ram_wr_addr;
  logic [ADDR_W-1:0]     ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  // in_ready depends only on registered full flags, so a bank being freed this
  // cycle is never refilled in the same cycle.
  assign in_ready    = !full_q[wr_bank_q];
  assign ram_wr_addr = {wr_bank_q, wr_idx_q};

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    frames_in_d = frames_in_q;
    wr_fire     = in_valid && in_ready;
    wr_last     = wr_fire && (wr_idx_q == LAST_IDX);
    if (wr_fire) begin
      if (wr_last) begin
        wr_idx_d    = '0;
        wr_bank_d   = ~wr_bank_q;
        frames_in_d = frames_in_q + CNT_WIDTH'(1);
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    rd_bank_d    = rd_bank_q;
    rd_idx_d     = rd_idx_q;
    frames_out_d = frames_out_q;
    next_out     = 1'b0;
    out_valid    = 1'b0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = {rd_bank_q, rd_idx_q};

    // Write and read always target different banks, so set and clear never meet.
    if (wr_last) begin
      full_d[wr_bank_q] = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Word 0 is fetched here so it lands on the first STREAM cycle.
        next_out    = 1'b1;
        rd_idx_d    = '0;
        ram_rd_en   = 1'b1;
        ram_rd_addr = {rd_bank_q, IDX_W'(0)};
        state_d     = STREAM;
      end
      STREAM: begin
        out_valid = 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          rd_idx_d          = '0;
          frames_out_d      = frames_out_q + CNT_WIDTH'(1);
          state_d           = full_q[~rd_bank_q] ? LAUNCH : IDLE;
        end else begin
          rd_idx_d    = rd_idx_q + IDX_W'(1);
          ram_rd_en   = 1'b1;
          ram_rd_addr = {rd_bank_q, rd_idx_q + IDX_W'(1)};
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      wr_idx_q     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      wr_idx_q     <= wr_idx_d;
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
    end
  end

  fft_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_bank (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (ram_wr_addr),
    .wr_data (in_data),
    .rd_en   (ram_rd_en),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // The RAM read register is not reset, so the output is gated by state.
  assign data_out   = (state_q == STREAM) ? ram_rd_data : '0;
  assign busy       = (|full_q) || (wr_idx_q != '0) || (state_q != IDLE);
  assign frames_in  = frames_in_q;
  assign frames_out = frames_out_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Directed bench for fft_frame_feeder with a word scoreboard and burst timing checks.
module tb_fft_frame_feeder;

  localparam int DW = 512;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [DW-1:0] data_out;
  logic          next_out;
  logic          out_valid;
  logic          busy;
  logic [CW-1:0] frames_in;
  logic [CW-1:0] frames_out;

  fft_frame_feeder #(
    .DATA_WIDTH  (DW),
    .FRAME_WORDS (4),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .next_out   (next_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .frames_in  (frames_in),
    .frames_out (frames_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            launch_q[$];
  int            out_cyc_q[$];
  int            acc[16];
  int            stl[16];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mk(input int k);
    return {16{32'(k) ^ 32'hA5A5_0000}};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input logic [DW-1:0] w, output int acc_cyc, output int stalls);
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (!in_ready) begin
      chk("push_timeout", 512'(in_ready), 512'd1);
      in_valid = 1'b0;
      acc_cyc  = cyc;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    exp_q.push_back(w);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_busy"}, 512'(busy), 512'd0);
    chk({tag, "_sb_left"}, 512'(exp_q.size()), 512'd0);
  endtask

  task automatic clear_logs();
    launch_q.delete();
    out_cyc_q.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("next_in_stream", 512'(next_out & out_valid), 512'd0);
      if (next_out) launch_q.push_back(cyc);
      if (out_valid) begin
        out_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("sb_unexpected_word", 512'(out_valid), 512'd0);
        else chk("data_word", data_out, exp_q.pop_front());
      end else begin
        chk("idle_data_zero", data_out, '0);
      end
    end
  end

  initial begin
    int t;
    int k;
    int ssum;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", 512'(in_ready), 512'd1);
    chk("rst_next_out", 512'(next_out), 512'd0);
    chk("rst_out_valid", 512'(out_valid), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_frames_in", 512'(frames_in), 512'd0);
    chk("rst_frames_out", 512'(frames_out), 512'd0);
    chk("rst_data_out", data_out, '0);
    mon_en = 1'b1;

    // Single frame 0x1..0x4
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(512'(i + 1), acc[i], stl[i]);
    t = acc[3];
    while (cyc < t + 6) @(negedge clk);
    chk("single_busy_t6", 512'(busy), 512'd1);
    @(negedge clk);
    chk("single_busy_t7", 512'(busy), 512'd0);
    chk("single_launch_cnt", 512'(launch_q.size()), 512'd1);
    if (launch_q.size() > 0) chk("single_launch_cyc", 512'(launch_q[0]), 512'(t + 2));
    chk("single_word_cnt", 512'(out_cyc_q.size()), 512'd4);
    for (int i = 0; i < 4 && i < out_cyc_q.size(); i++)
      chk("single_word_cyc", 512'(out_cyc_q[i]), 512'(t + 3 + i));
    chk("single_frames_in", 512'(frames_in), 512'd1);
    chk("single_frames_out", 512'(frames_out), 512'd1);
    wait_idle("single");

    // Irregular arrival, gaps 0/3/7
    clear_logs();
    push_word(mk(10), acc[0], stl[0]);
    push_word(mk(11), acc[1], stl[1]);
    repeat (3) @(negedge clk);
    push_word(mk(12), acc[2], stl[2]);
    repeat (7) @(negedge clk);
    push_word(mk(13), acc[3], stl[3]);
    t = acc[3];
    wait_idle("irreg");
    chk("irreg_launch_cnt", 512'(launch_q.size()), 512'd1);
    if (launch_q.size() > 0) chk("irreg_launch_cyc", 512'(launch_q[0]), 512'(t + 2));
    chk("irreg_word_cnt", 512'(out_cyc_q.size()), 512'd4);
    for (int i = 0; i < 4 && i < out_cyc_q.size(); i++)
      chk("irreg_word_cyc", 512'(out_cyc_q[i]), 512'(t + 3 + i));

    // Back-to-back launch: both banks filled before the first stream ends
    clear_logs();
    for (int i = 0; i < 8; i++) push_word(mk(20 + i), acc[i], stl[i]);
    wait_idle("b2b");
    chk("b2b_launch_cnt", 512'(launch_q.size()), 512'd2);
    chk("b2b_word_cnt", 512'(out_cyc_q.size()), 512'd8);
    if (launch_q.size() == 2 && out_cyc_q.size() == 8) begin
      chk("b2b_launch_gap", 512'(launch_q[1]), 512'(out_cyc_q[3] + 1));
      chk("b2b_stream_gap", 512'(out_cyc_q[4]), 512'(launch_q[1] + 1));
    end

    // Back-pressure: 12 continuous words
    clear_logs();
    for (int i = 0; i < 12; i++) push_word(mk(40 + i), acc[i], stl[i]);
    wait_idle("bp");
    chk("bp_word9_stall", 512'(stl[8]), 512'd2);
    chk("bp_word9_accept", 512'(acc[8] - acc[7]), 512'd3);
    ssum = 0;
    for (int i = 0; i < 12; i++) ssum += stl[i];
    chk("bp_total_stall", 512'(ssum), 512'd2);
    chk("bp_launch_cnt", 512'(launch_q.size()), 512'd3);
    chk("bp_word_cnt", 512'(out_cyc_q.size()), 512'd12);
    if (launch_q.size() == 3 && out_cyc_q.size() == 12)
      chk("bp_launch_gap", 512'(launch_q[1]), 512'(out_cyc_q[3] + 1));
    chk("bp_frames_in", 512'(frames_in), 512'd7);
    chk("bp_frames_out", 512'(frames_out), 512'd7);

    // Reset during the second STREAM word
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(mk(60 + i), acc[i], stl[i]);
    k = 0;
    while (next_out !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("mrst_launch_seen", 512'(next_out), 512'd1);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_in_word1", 512'(out_valid), 512'd1);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
    chk("mrst_out_valid", 512'(out_valid), 512'd0);
    chk("mrst_next_out", 512'(next_out), 512'd0);
    chk("mrst_frames_in", 512'(frames_in), 512'd0);
    chk("mrst_frames_out", 512'(frames_out), 512'd0);
    chk("mrst_in_ready", 512'(in_ready), 512'd1);
    chk("mrst_busy", 512'(busy), 512'd0);
    reset = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++) push_word(mk(70 + i), acc[i], stl[i]);
    t = acc[3];
    wait_idle("mrst_fresh");
    if (launch_q.size() > 0) chk("mrst_fresh_launch", 512'(launch_q[0]), 512'(t + 2));
    chk("mrst_fresh_words", 512'(out_cyc_q.size()), 512'd4);
    chk("mrst_fresh_frames_in", 512'(frames_in), 512'd1);
    chk("mrst_fresh_frames_out", 512'(frames_out), 512'd1);

    // Counter wrap of frames_out
    force dut.frames_out_q = {CW{1'b1}};
    @(negedge clk);
    @(negedge clk);
    release dut.frames_out_q;
    @(negedge clk);
    chk("wrap_preload", 512'(frames_out), 512'(32'hFFFF_FFFF));
    for (int i = 0; i < 4; i++) push_word(mk(80 + i), acc[i], stl[i]);
    wait_idle("wrap");
    chk("wrap_frames_out", 512'(frames_out), 512'd0);
    chk("wrap_frames_in", 512'(frames_in), 512'd2);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
